// File: rtl/seq_detect_pkg.sv
// Shared types and sizing helpers for the programmable serial sequence detector.
package seq_detect_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Width able to hold any length 0..pat_w.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Config, control, serial-data and status bundle of the sequence detector.
interface seq_detect_ctrl_if
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int LEN_W = len_w(PAT_W);

    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             start;
    logic             stop;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, stop, w, w_valid,
        input  busy, z, match_cnt, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, stop, w, w_valid,
        output busy, z, match_cnt, cfg_err
    );

endinterface

// File: rtl/seq_window_shreg.sv
// Serial window shift register with a length-masked compare of the post-shift window.
module seq_window_shreg #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift,
    input  logic             w,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);
    logic [PAT_W-1:0] win_q, win_d, win_next, mask;

    // hit reflects the window as it will be once w is shifted in, so the
    // controller can register the match on the same edge that samples w.
    always_comb begin
        win_next = {win_q[PAT_W-2:0], w};
        mask     = ~({PAT_W{1'b1}} << len);
        hit      = ((win_next ^ pattern) & mask) == '0;
        win_d    = win_q;
        if (clr) begin
            win_d = '0;
        end else if (shift) begin
            win_d = win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence-detector controller: config registers, IDLE/FILL/RUN FSM, match pulse and
// saturating match counter around a seq_window_shreg.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    seq_detect_ctrl_if.slave bus
);
    localparam int LEN_W = len_w(PAT_W);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ov_q, ov_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] bits_q, bits_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;

    logic             cfg_ok, win_clr, win_shift, match, hit;
    logic [LEN_W-1:0] bits_inc;

    seq_window_shreg #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (win_clr),
        .shift   (win_shift),
        .w       (bus.w),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ov_d      = ov_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        bits_d    = bits_q;
        z_d       = 1'b0;
        win_clr   = 1'b0;
        win_shift = 1'b0;
        match     = 1'b0;
        bits_inc  = bits_q + 1'b1;
        cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN);

        case (state_q)
            IDLE: begin
                if (bus.cfg_we) begin
                    if (cfg_ok) begin
                        pat_d = bus.cfg_pattern;
                        len_d = bus.cfg_len;
                        ov_d  = bus.cfg_overlap;
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // A rejected config write in the same cycle also suppresses start.
                if (bus.start && !bus.stop && (!bus.cfg_we || cfg_ok)) begin
                    cnt_d   = '0;
                    bits_d  = '0;
                    win_clr = 1'b1;
                    state_d = FILL;
                end
            end
            default: begin
                if (bus.cfg_we) begin
                    err_d = 1'b1;
                end
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.w_valid) begin
                    win_shift = 1'b1;
                    if (state_q == FILL) begin
                        bits_d = bits_inc;
                        if (bits_inc == len_q) begin
                            state_d = RUN;
                            match   = hit;
                        end
                    end else begin
                        match = hit;
                    end
                    // Non-overlapping mode demands len fresh bits before the next compare.
                    if (match && !ov_q) begin
                        bits_d  = '0;
                        state_d = FILL;
                    end
                end
            end
        endcase

        if (match) begin
            z_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= LEN_W'(1);
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            bits_q  <= '0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.z         = z_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: vector table, hand-written corner sequences, and random
// stimulus against a bit-history reference model. Two DUTs (CNT_W=8 and CNT_W=2) share stimulus.
module tb_seq_detect_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.PAT_W(8), .CNT_W(8)) bus0 ();
    seq_detect_ctrl_if #(.PAT_W(8), .CNT_W(2)) bus2 ();

    assign bus2.cfg_we      = bus0.cfg_we;
    assign bus2.cfg_pattern = bus0.cfg_pattern;
    assign bus2.cfg_len     = bus0.cfg_len;
    assign bus2.cfg_overlap = bus0.cfg_overlap;
    assign bus2.start       = bus0.start;
    assign bus2.stop        = bus0.stop;
    assign bus2.w           = bus0.w;
    assign bus2.w_valid     = bus0.w_valid;

    seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    seq_detect_ctrl #(.PAT_W(8), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic       r, we;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov, st, sp, w, wv;
        int         ez, eb, ee, ec, ec2;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit       m_active;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ov, m_err, m_z;
    int       m_cnt, m_cnt2;
    bit       hist[$];

    function automatic vec_t mk(input logic r, we, input logic [7:0] pat, input logic [3:0] len,
                                input logic ov, st, sp, w, wv,
                                input int ez, eb, ee, ec, ec2);
        vec_t v;
        v.r = r; v.we = we; v.pat = pat; v.len = len; v.ov = ov;
        v.st = st; v.sp = sp; v.w = w; v.wv = wv;
        v.ez = ez; v.eb = eb; v.ee = ee; v.ec = ec; v.ec2 = ec2;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs[nvec] = v;
        nvec++;
    endtask

    task automatic drive(input logic r, we, input logic [7:0] pat, input logic [3:0] len,
                         input logic ov, st, sp, w, wv);
        rst_n            = r;
        bus0.cfg_we      = we;
        bus0.cfg_pattern = pat;
        bus0.cfg_len     = len;
        bus0.cfg_overlap = ov;
        bus0.start       = st;
        bus0.stop        = sp;
        bus0.w           = w;
        bus0.w_valid     = wv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ez, eb, ee, ec, ec2);
        check({tag, " z"},     int'(bus0.z),         ez);
        check({tag, " busy"},  int'(bus0.busy),      eb);
        check({tag, " err"},   int'(bus0.cfg_err),   ee);
        check({tag, " cnt"},   int'(bus0.match_cnt), ec);
        check({tag, " cnt2"},  int'(bus2.match_cnt), ec2);
        check({tag, " z2"},    int'(bus2.z),         ez);
    endtask

    // Model works from the specification's rules: a bit history since the last
    // start (or last non-overlapping match) and a tail compare against the pattern.
    task automatic model_step();
        bit ok, tail;
        m_z = 1'b0;
        if (!rst_n) begin
            m_active = 0; m_pat = '0; m_len = 1; m_ov = 0; m_err = 0;
            m_cnt = 0; m_cnt2 = 0; hist.delete();
        end else if (!m_active) begin
            ok = (bus0.cfg_len >= 1) && (bus0.cfg_len <= 8);
            if (bus0.cfg_we) begin
                if (ok) begin
                    m_pat = bus0.cfg_pattern; m_len = int'(bus0.cfg_len);
                    m_ov = bus0.cfg_overlap; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (bus0.start && !bus0.stop && (!bus0.cfg_we || ok)) begin
                m_active = 1; m_cnt = 0; m_cnt2 = 0; hist.delete();
            end
        end else begin
            if (bus0.cfg_we) m_err = 1;
            if (bus0.stop) begin
                m_active = 0;
            end else if (bus0.w_valid) begin
                hist.push_back(bus0.w);
                if (hist.size() > 8) void'(hist.pop_front());
                if (hist.size() >= m_len) begin
                    tail = 1;
                    for (int i = 0; i < m_len; i++)
                        if (hist[hist.size() - 1 - i] != m_pat[i]) tail = 0;
                    if (tail) begin
                        m_z = 1;
                        if (m_cnt < 255) m_cnt++;
                        if (m_cnt2 < 3) m_cnt2++;
                        if (!m_ov) hist.delete();
                    end
                end
            end
        end
    endtask

    initial begin
        // r, we, pat, len, ov, st, sp, w, wv  |  z, busy, err, cnt, cnt2
        add(mk(0,0,8'h00,0,0,0,0,0,0, 0,0,0,0,0));
        // falling edge "10", non-overlap, stream 1,1,0,1,0
        add(mk(1,1,8'h02,2,0,0,0,0,0, 0,0,0,0,0));
        add(mk(1,0,8'h00,0,0,1,0,0,0, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,0,1, 1,1,0,1,1));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 0,1,0,1,1));
        add(mk(1,0,8'h00,0,0,0,0,0,1, 1,1,0,2,2));
        add(mk(1,0,8'h00,0,0,0,1,0,0, 0,0,0,2,2));
        // "101" overlap=1 with config+start together
        add(mk(1,1,8'h05,3,1,1,0,0,0, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,0,1, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 1,1,0,1,1));
        add(mk(1,0,8'h00,0,0,0,0,0,1, 0,1,0,1,1));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 1,1,0,2,2));
        add(mk(1,0,8'h00,0,0,0,1,0,0, 0,0,0,2,2));
        // "101" overlap=0
        add(mk(1,1,8'h05,3,0,1,0,0,0, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,0,1, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 1,1,0,1,1));
        add(mk(1,0,8'h00,0,0,0,0,0,1, 0,1,0,1,1));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 0,1,0,1,1));
        add(mk(1,0,8'h00,0,0,0,1,0,0, 0,0,0,1,1));
        // cfg_len=0 rejected; old "101" config still detects
        add(mk(1,1,8'hFF,0,1,0,0,0,0, 0,0,1,1,1));
        add(mk(1,0,8'h00,0,0,1,0,0,0, 0,1,1,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 0,1,1,0,0));
        add(mk(1,0,8'h00,0,0,0,0,0,1, 0,1,1,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 1,1,1,1,1));
        add(mk(1,0,8'h00,0,0,0,1,0,0, 0,0,1,1,1));
        // valid write clears err; write while busy sets err, config unchanged
        add(mk(1,1,8'h05,3,0,0,0,0,0, 0,0,0,1,1));
        add(mk(1,0,8'h00,0,0,1,0,0,0, 0,1,0,0,0));
        add(mk(1,1,8'h03,2,1,0,0,0,0, 0,1,1,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 0,1,1,0,0));
        add(mk(1,0,8'h00,0,0,0,0,0,1, 0,1,1,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 1,1,1,1,1));
        add(mk(1,0,8'h00,0,0,0,1,0,0, 0,0,1,1,1));
        // len=1, pattern 1: six ones, counter saturation on the CNT_W=2 instance
        add(mk(1,1,8'h01,1,0,0,0,0,0, 0,0,0,1,1));
        add(mk(1,0,8'h00,0,0,1,0,0,0, 0,1,0,0,0));
        for (int k = 1; k <= 6; k++)
            add(mk(1,0,8'h00,0,0,0,0,1,1, 1,1,0,k,(k > 3) ? 3 : k));
        add(mk(1,0,8'h00,0,0,0,0,1,0, 0,1,0,6,3));
        // start ignored while running; stop wins
        add(mk(1,0,8'h00,0,0,1,1,0,0, 0,0,0,6,3));
        add(mk(1,0,8'h00,0,0,1,1,0,0, 0,0,0,6,3));
        add(mk(1,0,8'h00,0,0,1,0,0,0, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,0,0,1, 0,1,0,0,0));
        add(mk(1,0,8'h00,0,0,0,1,1,1, 0,0,0,0,0));
        // invalid config with start: start ignored
        add(mk(1,1,8'h00,9,0,1,0,0,0, 0,0,1,0,0));
        add(mk(1,0,8'h00,0,0,0,0,1,1, 0,0,1,0,0));

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].r, vecs[i].we, vecs[i].pat, vecs[i].len, vecs[i].ov,
                  vecs[i].st, vecs[i].sp, vecs[i].w, vecs[i].wv);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ez, vecs[i].eb, vecs[i].ee,
                      vecs[i].ec, vecs[i].ec2);
        end

        // Reset while z is high and err is set
        drive(1,1,8'h01,1,0,0,0,0,0); tick();
        drive(1,0,8'h00,0,0,1,0,0,0); tick();
        drive(1,1,8'h00,2,0,0,0,1,1); tick();
        check_all("pre_rst", 1,1,1,1,1);
        drive(0,0,8'h00,0,0,0,0,1,1); tick();
        check_all("mid_rst", 0,0,0,0,0);
        // Stored pattern lost: a 1 no longer matches
        drive(1,0,8'h00,0,0,1,0,0,0); tick();
        drive(1,0,8'h00,0,0,0,0,1,1); tick();
        check_all("post_rst_cfg_lost", 0,1,0,0,0);
        drive(1,0,8'h00,0,0,0,1,0,0); tick();
        drive(1,1,8'h01,1,0,1,0,0,0); tick();
        drive(1,0,8'h00,0,0,0,0,1,1); tick();
        check_all("post_rst_resume", 1,1,0,1,1);
        drive(1,0,8'h00,0,0,0,1,0,0); tick();

        // Stop in FILL with a bit that would complete "10"
        drive(1,1,8'h02,2,0,1,0,0,0); tick();
        drive(1,0,8'h00,0,0,0,0,1,1); tick();
        drive(1,0,8'h00,0,0,0,1,0,1); tick();
        check_all("stop_fill", 0,0,0,0,0);
        drive(1,0,8'h00,0,0,0,0,0,0); tick();
        check_all("stop_fill_idle", 0,0,0,0,0);

        // Randomized stimulus against the model
        drive(0,0,8'h00,0,0,0,0,0,0);
        model_step(); tick();
        for (int c = 0; c < 4000; c++) begin
            drive(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 9) == 0),
                  8'($urandom),
                  4'($urandom_range(0, 10)),
                  1'($urandom),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 24) == 0),
                  1'($urandom),
                  ($urandom_range(0, 3) != 0));
            model_step();
            tick();
            check_all($sformatf("rnd%0d", c), int'(m_z), int'(m_active), int'(m_err),
                      m_cnt, m_cnt2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
